// File: rtl/mem_bus_iface.sv
// Memory bus interface unit: latches one CPU request, runs a single READY-handshaked
// memory access with minimum wait states. Optional abort timer: define MEM_BIU_TIMEOUT_EN.
module mem_bus_iface #(
    parameter int unsigned MIN_WAIT    = 2,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [25:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    input  logic        i_cpu_read,
    input  logic        i_cpu_write,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_busy,
    output logic [25:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_read,
    output logic        o_mem_write,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ready,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    localparam logic [3:0] MIN_WAIT_C = 4'(MIN_WAIT);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [25:0] r_mem_addr, w_mem_addr_nxt;
    logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
    logic        r_mem_read, w_mem_read_nxt;
    logic        r_mem_write, w_mem_write_nxt;
    logic [31:0] r_cpu_rdata, w_cpu_rdata_nxt;

    logic w_req_legal;
    logic w_ready_ok;

`ifdef MEM_BIU_TIMEOUT_EN
    localparam logic [15:0] TCYC_M1 = 16'(TIMEOUT_CYC - 1);

    logic [15:0] r_tcnt, w_tcnt_nxt;
    logic        r_timeout, w_timeout_nxt;
`endif

    assign w_req_legal = i_cpu_read ^ i_cpu_write;
    assign w_ready_ok  = i_mem_ready && (r_cnt >= MIN_WAIT_C);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_cpu_rdata <= '0;
`ifdef MEM_BIU_TIMEOUT_EN
            r_tcnt      <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_read  <= w_mem_read_nxt;
            r_mem_write <= w_mem_write_nxt;
            r_cpu_rdata <= w_cpu_rdata_nxt;
`ifdef MEM_BIU_TIMEOUT_EN
            r_tcnt      <= w_tcnt_nxt;
            r_timeout   <= w_timeout_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_read_nxt  = r_mem_read;
        w_mem_write_nxt = r_mem_write;
        w_cpu_rdata_nxt = r_cpu_rdata;
`ifdef MEM_BIU_TIMEOUT_EN
        w_tcnt_nxt      = r_tcnt;
        w_timeout_nxt   = r_timeout;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (w_req_legal) begin
                    w_state_nxt     = ST_ACCESS;
                    w_cnt_nxt       = '0;
                    w_mem_addr_nxt  = i_cpu_addr;
                    w_mem_wdata_nxt = i_cpu_wdata;
                    w_mem_read_nxt  = i_cpu_read;
                    w_mem_write_nxt = i_cpu_write;
`ifdef MEM_BIU_TIMEOUT_EN
                    w_tcnt_nxt      = '0;
                    w_timeout_nxt   = 1'b0;
`endif
                end
            end
            ST_ACCESS: begin
                if (r_cnt != 4'hF) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
`ifdef MEM_BIU_TIMEOUT_EN
                w_tcnt_nxt = r_tcnt + 16'd1;
`endif
                // READY at the expiry edge takes priority over the abort.
                if (w_ready_ok) begin
                    w_state_nxt     = ST_DONE;
                    w_mem_read_nxt  = 1'b0;
                    w_mem_write_nxt = 1'b0;
                    if (r_mem_read) begin
                        w_cpu_rdata_nxt = i_mem_rdata;
                    end
                end
`ifdef MEM_BIU_TIMEOUT_EN
                else if (r_tcnt == TCYC_M1) begin
                    w_state_nxt     = ST_DONE;
                    w_mem_read_nxt  = 1'b0;
                    w_mem_write_nxt = 1'b0;
                    w_timeout_nxt   = 1'b1;
                    if (r_mem_read) begin
                        w_cpu_rdata_nxt = '1;
                    end
                end
`endif
            end
            ST_DONE: begin
                if (!i_cpu_read && !i_cpu_write) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Stall is raised combinationally in the request cycle so the sequencer never advances.
    assign o_cpu_busy  = (r_state == ST_ACCESS) || ((r_state == ST_IDLE) && w_req_legal && !i_rst);
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_read  = r_mem_read;
    assign o_mem_write = r_mem_write;
`ifdef MEM_BIU_TIMEOUT_EN
    assign o_timeout   = r_timeout;
`else
    assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_iface.sv
// Self-checking bench for mem_bus_iface: transaction-level reference model compared
// every falling edge, plus directed scenarios with literal expectations.
module tb_mem_bus_iface;

    localparam int MIN_WAIT    = 2;
    localparam int TIMEOUT_CYC = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [25:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_busy;
    logic [25:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        timeout;

    int n_tests = 0;
    int n_fail  = 0;

    mem_bus_iface #(.MIN_WAIT(MIN_WAIT), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .i_cpu_read  (cpu_read),
        .i_cpu_write (cpu_write),
        .o_cpu_rdata (cpu_rdata),
        .o_cpu_busy  (cpu_busy),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_read  (mem_read),
        .o_mem_write (mem_write),
        .i_mem_rdata (mem_rdata),
        .i_mem_ready (mem_ready),
        .o_timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, its age, and a release latch.
    logic        m_inflight = 1'b0;
    logic        m_hold     = 1'b0;
    logic        m_is_read  = 1'b0;
    logic [25:0] m_addr     = '0;
    logic [31:0] m_wdata    = '0;
    logic [31:0] m_rdata    = '0;
    logic        m_timeout  = 1'b0;
    int          m_age      = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_inflight <= 1'b0;
            m_hold     <= 1'b0;
            m_is_read  <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_rdata    <= '0;
            m_timeout  <= 1'b0;
            m_age      <= 0;
        end else if (m_inflight) begin
            m_age <= m_age + 1;
            if (mem_ready && m_age >= MIN_WAIT) begin
                m_inflight <= 1'b0;
                m_hold     <= 1'b1;
                if (m_is_read) m_rdata <= mem_rdata;
            end
`ifdef MEM_BIU_TIMEOUT_EN
            else if (m_age + 1 == TIMEOUT_CYC) begin
                m_inflight <= 1'b0;
                m_hold     <= 1'b1;
                m_timeout  <= 1'b1;
                if (m_is_read) m_rdata <= 32'hFFFF_FFFF;
            end
`endif
        end else if (m_hold) begin
            if (!cpu_read && !cpu_write) m_hold <= 1'b0;
        end else if (cpu_read != cpu_write) begin
            m_inflight <= 1'b1;
            m_is_read  <= cpu_read;
            m_addr     <= cpu_addr;
            m_wdata    <= cpu_wdata;
            m_age      <= 0;
            m_timeout  <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("busy",   {31'b0, cpu_busy},
            {31'b0, m_inflight || (!m_hold && (cpu_read != cpu_write) && !rst)});
        chk("mem_read",  {31'b0, mem_read},  {31'b0, m_inflight && m_is_read});
        chk("mem_write", {31'b0, mem_write}, {31'b0, m_inflight && !m_is_read});
        chk("mem_addr",  {6'b0, mem_addr},   {6'b0, m_addr});
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("cpu_rdata", cpu_rdata, m_rdata);
        chk("timeout",   {31'b0, timeout},   {31'b0, m_timeout});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Counts consecutive cycles with a strobe high, starting at the current sample.
    task automatic count_strobe(output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!(mem_read || mem_write)) return;
            n++;
            step();
        end
        n_tests++;
        n_fail++;
        $display("FAIL strobe_bound: strobe still high after %0d cycles, required low", n);
    endtask

    task automatic release_req();
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        step();
        step();
    endtask

    initial begin
        int n;

        repeat (3) step();
        chk("rst_busy",  {31'b0, cpu_busy}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_addr",  {6'b0, mem_addr}, 32'd0);
        rst = 1'b0;
        step();

        // Read, READY held high: three strobe cycles at MIN_WAIT=2.
        cpu_addr  = 26'h10;
        mem_rdata = 32'hA5A5_0001;
        mem_ready = 1'b1;
        cpu_read  = 1'b1;
        #1;
        chk("req_busy_comb", {31'b0, cpu_busy}, 32'd1);
        step();
        count_strobe(n);
        chk("rd_cycles", n, 32'd3);
        chk("rd_data",   cpu_rdata, 32'hA5A5_0001);
        chk("rd_addr",   {6'b0, mem_addr}, 32'h10);
        chk("rd_busy",   {31'b0, cpu_busy}, 32'd0);
        repeat (3) step();
        chk("rd_no_reissue", {31'b0, mem_read}, 32'd0);
        release_req();

        // Write, READY first high in the fifth ACCESS cycle; CPU inputs change mid-access.
        mem_ready = 1'b0;
        cpu_addr  = 26'h2A;
        cpu_wdata = 32'h1234_5678;
        cpu_write = 1'b1;
        step();
        n = 0;
        cpu_wdata = 32'hDEAD_BEEF;
        cpu_addr  = 26'h3FF_FFFF;
        for (int k = 0; k < 4; k++) begin
            if (mem_write) n++;
            step();
        end
        if (mem_write) n++;
        mem_ready = 1'b1;
        step();
        chk("wr_cycles", n, 32'd5);
        chk("wr_strobe_low", {31'b0, mem_write}, 32'd0);
        chk("wr_wdata", mem_wdata, 32'h1234_5678);
        chk("wr_addr",  {6'b0, mem_addr}, 32'h2A);
        repeat (3) step();
        chk("wr_no_reissue", {31'b0, mem_write}, 32'd0);
        release_req();

        // Both requests high: illegal, ignored.
        cpu_read  = 1'b1;
        cpu_write = 1'b1;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (mem_read || mem_write || cpu_busy) n++;
        end
        chk("illegal_activity", n, 32'd0);
        release_req();

        // Back-to-back reads with one idle request cycle between them.
        cpu_addr  = 26'h40;
        mem_rdata = 32'h1111_1111;
        cpu_read  = 1'b1;
        step();
        count_strobe(n);
        chk("b2b_first", cpu_rdata, 32'h1111_1111);
        cpu_read  = 1'b0;
        cpu_addr  = 26'h41;
        mem_rdata = 32'h2222_2222;
        step();
        cpu_read = 1'b1;
        step();
        chk("b2b_addr", {6'b0, mem_addr}, 32'h41);
        chk("b2b_hold", cpu_rdata, 32'h1111_1111);
        count_strobe(n);
        chk("b2b_second", cpu_rdata, 32'h2222_2222);
        release_req();

        // Reset pulse mid-access, then a normal read.
        mem_ready = 1'b0;
        cpu_addr  = 26'h33;
        cpu_read  = 1'b1;
        step();
        step();
        chk("pre_rst_busy", {31'b0, cpu_busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_strobe", {31'b0, mem_read}, 32'd0);
        chk("rst_mid_busy",   {31'b0, cpu_busy}, 32'd0);
        chk("rst_mid_rdata",  cpu_rdata, 32'd0);
        step();
        rst       = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_0002;
        step();
        count_strobe(n);
        chk("post_rst_cycles", n, 32'd3);
        chk("post_rst_rdata", cpu_rdata, 32'hCAFE_0002);
        release_req();

`ifdef MEM_BIU_TIMEOUT_EN
        // No READY: abort after TIMEOUT_CYC cycles.
        mem_ready = 1'b0;
        cpu_addr  = 26'h50;
        cpu_read  = 1'b1;
        step();
        count_strobe(n);
        chk("to_cycles", n, 32'd8);
        chk("to_flag",   {31'b0, timeout}, 32'd1);
        chk("to_rdata",  cpu_rdata, 32'hFFFF_FFFF);
        chk("to_busy",   {31'b0, cpu_busy}, 32'd0);
        release_req();
        // READY on the expiry edge completes normally; the flag clears on request.
        cpu_addr  = 26'h51;
        mem_rdata = 32'h0000_0077;
        cpu_read  = 1'b1;
        step();
        chk("to_cleared", {31'b0, timeout}, 32'd0);
        repeat (7) step();
        mem_ready = 1'b1;
        step();
        chk("to_edge_flag",  {31'b0, timeout}, 32'd0);
        chk("to_edge_rdata", cpu_rdata, 32'h0000_0077);
        release_req();
`else
        // No timeout: a stalled access waits indefinitely.
        mem_ready = 1'b0;
        cpu_addr  = 26'h50;
        mem_rdata = 32'h0000_0077;
        cpu_read  = 1'b1;
        step();
        repeat (20) step();
        chk("wait_busy",  {31'b0, cpu_busy}, 32'd1);
        chk("wait_flag",  {31'b0, timeout}, 32'd0);
        mem_ready = 1'b1;
        count_strobe(n);
        chk("wait_cycles", n, 32'd1);
        chk("wait_rdata", cpu_rdata, 32'h0000_0077);
        release_req();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
